// File: rtl/fmult_accum_seq.sv
// Time-multiplexed G.726 FMULT/ACCUM engine: walks NTAPS coefficient/signal pairs
// through one shared float multiplier and accumulates SEZ and SE once per sample.
module fmult_accum_seq #(
   parameter int unsigned NTAPS = 8,
   parameter int unsigned NZ    = 6,
   parameter int unsigned IDX_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             scan_in0,
   input  logic             scan_in1,
   input  logic             scan_in2,
   input  logic             scan_in3,
   input  logic             scan_in4,
   input  logic             scan_enable,
   input  logic             test_mode,
   output logic             scan_out0,
   output logic             scan_out1,
   output logic             scan_out2,
   output logic             scan_out3,
   output logic             scan_out4,
   input  logic             start,
   output logic [IDX_W-1:0] tap_idx,
   input  logic [15:0]      coef_in,
   input  logic [10:0]      sig_in,
   output logic [15:0]      wterm,
   output logic             wterm_valid,
   output logic             busy,
   output logic             done,
   output logic [14:0]      sez,
   output logic [14:0]      se
);

   localparam int unsigned ACC_W = 16;
   localparam int unsigned OUT_W = 15;
   localparam int unsigned MAG_W = 13;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   tap_idx_q, tap_idx_d;
   logic               fetch_vld_q, fetch_vld_d;
   logic [IDX_W-1:0]   fetch_idx_q, fetch_idx_d;
   logic [ACC_W-1:0]   wterm_q, wterm_d;
   logic               wvld_q, wvld_d;
   logic [IDX_W-1:0]   widx_q, widx_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [ACC_W-1:0]   snap_q, snap_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               drain_q, drain_d;
   logic [OUT_W-1:0]   sez_q, sez_d;
   logic [OUT_W-1:0]   se_q, se_d;

   // Scan ports are placeholders until DFT insertion stitches the chains.
   logic dft_unused;
   assign dft_unused = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                         scan_enable, test_mode};
   assign scan_out0 = 1'b0;
   assign scan_out1 = 1'b0;
   assign scan_out2 = 1'b0;
   assign scan_out3 = 1'b0;
   assign scan_out4 = 1'b0;

   logic [MAG_W-1:0] mag_c;
   logic [3:0]       aexp_c;
   logic [5:0]       amant_c;
   logic [11:0]      wmant_c;
   logic [4:0]       wexp_c;
   logic [16:0]      m_c;
   logic [14:0]      wmag_c;
   logic [15:0]      prod_c;

   // Shared floating-point multiplier on the fetched coefficient/signal pair.
   always_comb begin
      mag_c = coef_in[15] ? MAG_W'(13'd0 - 13'(coef_in >> 2)) : MAG_W'(coef_in >> 2);
      aexp_c = 4'd0;
      for (int i = 0; i < int'(MAG_W); i++) begin
         if (mag_c[i]) aexp_c = 4'(i + 1);
      end
      amant_c = (mag_c == '0) ? 6'h20 : 6'({mag_c, 6'b0} >> aexp_c);
      wmant_c = 12'(amant_c) * 12'(sig_in[5:0]) + 12'h030;
      wexp_c  = 5'(aexp_c) + 5'(sig_in[9:6]);
      m_c     = 17'(wmant_c >> 4) << 7;
      if (wexp_c <= 5'd26) wmag_c = 15'(m_c >> (5'd26 - wexp_c));
      else                 wmag_c = 15'(m_c << (wexp_c - 5'd26));
      prod_c = (coef_in[15] ^ sig_in[10]) ? 16'(16'd0 - 16'(wmag_c)) : 16'(wmag_c);
   end

   // Next-state, pipeline and accumulator logic.
   always_comb begin
      state_d     = state_q;
      tap_idx_d   = tap_idx_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      drain_d     = drain_q;
      sez_d       = sez_q;
      se_d        = se_q;
      fetch_vld_d = (state_q == S_FETCH);
      fetch_idx_d = tap_idx_q;
      wvld_d      = fetch_vld_q;
      wterm_d     = fetch_vld_q ? prod_c : wterm_q;
      widx_d      = fetch_vld_q ? fetch_idx_q : widx_q;
      acc_d       = acc_q;
      snap_d      = snap_q;

      if (wvld_q) begin
         acc_d = acc_q + wterm_q;
         if (widx_q == IDX_W'(NZ - 1)) snap_d = acc_d;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_FETCH;
               tap_idx_d = '0;
               busy_d    = 1'b1;
               acc_d     = '0;
               snap_d    = '0;
            end
         end
         S_FETCH: begin
            if (tap_idx_q == IDX_W'(NTAPS - 1)) begin
               state_d = S_DRAIN;
               drain_d = 1'b0;
            end else begin
               tap_idx_d = tap_idx_q + IDX_W'(1);
            end
         end
         S_DRAIN: begin
            drain_d = 1'b1;
            // Second drain cycle: the last product is being added right now.
            if (drain_q) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               sez_d   = snap_d[15:1];
               se_d    = acc_d[15:1];
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         tap_idx_q   <= '0;
         fetch_vld_q <= 1'b0;
         fetch_idx_q <= '0;
         wterm_q     <= '0;
         wvld_q      <= 1'b0;
         widx_q      <= '0;
         acc_q       <= '0;
         snap_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         drain_q     <= 1'b0;
         sez_q       <= '0;
         se_q        <= '0;
      end else begin
         state_q     <= state_d;
         tap_idx_q   <= tap_idx_d;
         fetch_vld_q <= fetch_vld_d;
         fetch_idx_q <= fetch_idx_d;
         wterm_q     <= wterm_d;
         wvld_q      <= wvld_d;
         widx_q      <= widx_d;
         acc_q       <= acc_d;
         snap_q      <= snap_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         drain_q     <= drain_d;
         sez_q       <= sez_d;
         se_q        <= se_d;
      end
   end

   assign tap_idx     = tap_idx_q;
   assign wterm       = wterm_q;
   assign wterm_valid = wvld_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign sez         = sez_q;
   assign se          = se_q;

endmodule
